// File: rtl/rvfpm_issue_ctrl.sv
// rvfpm_issue_ctrl
//   Issue/commit scheduler between the CORE-V-XIF coprocessor interface and
//   the rvfpm execution model. Offloaded FP instructions sit in a circular
//   slot queue from issue until commit. Killed entries are dropped at the head.
//   Committed entries go to the FPU model strictly in program order. A
//   per-register scoreboard holds back RAW/WAW hazards against in-flight
//   results.
//
// Ports
//   ck, rst            clock, synchronous active-high reset
//   issue_*            XIF issue handshake plus predecoded operand fields
//                      (issue_rs = {rs3,rs2,rs1}, issue_rs_valid bit k <-> rs(k+1))
//   commit_*           XIF commit (id, kill)
//   dispatch_*         in-order hand-off of the head instruction to the FPU model
//   retire_valid/rd    FPU result writeback; clears the scoreboard bit
//   count              occupied slots
//   busy               count != 0 or any scoreboard bit set
module rvfpm_issue_ctrl #(
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int NUM_REGS    = 32
) (
    input  logic                                   ck,
    input  logic                                   rst,
    input  logic                                   issue_valid,
    output logic                                   issue_ready,
    input  logic                                   issue_accept,
    input  logic [31:0]                            issue_instr,
    input  logic [X_ID_WIDTH-1:0]                  issue_id,
    input  logic [4:0]                             issue_rd,
    input  logic                                   issue_rd_we,
    input  logic [14:0]                            issue_rs,
    input  logic [2:0]                             issue_rs_valid,
    input  logic                                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]                  commit_id,
    input  logic                                   commit_kill,
    output logic                                   dispatch_valid,
    input  logic                                   dispatch_ready,
    output logic [31:0]                            dispatch_instr,
    output logic [X_ID_WIDTH-1:0]                  dispatch_id,
    input  logic                                   retire_valid,
    input  logic [4:0]                             retire_rd,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]       count,
    output logic                                   busy
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    // S_EMPTY must be the all-zero encoding so a cleared slot reads as empty.
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_GO, S_KILL} slot_st_e;

    typedef struct packed {
        slot_st_e              st;
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  rd_we;
        logic [14:0]           rs;
        logic [2:0]            rs_valid;
    } slot_t;

    slot_t [QUEUE_DEPTH-1:0] slots, slots_nxt;
    logic  [PW-1:0]          head, tail;
    logic  [NUM_REGS-1:0]    sb, sb_nxt;

    slot_t      head_slot;
    logic [2:0] src_hit;
    logic       hazard;
    logic       push, pop, pop_kill, fire;

    assign head_slot = slots[head];

    always_comb begin
        for (int k = 0; k < 3; k++)
            src_hit[k] = head_slot.rs_valid[k] && sb[head_slot.rs[5*k +: 5]];
    end

    assign hazard         = (|src_hit) || (head_slot.rd_we && sb[head_slot.rd]);
    assign issue_ready    = (count != CW'(QUEUE_DEPTH));
    assign dispatch_valid = (head_slot.st == S_GO) && !hazard;
    assign dispatch_instr = head_slot.instr;
    assign dispatch_id    = head_slot.id;
    assign busy           = (count != '0) || (|sb);

    assign push     = issue_valid && issue_ready && issue_accept;
    assign pop_kill = (head_slot.st == S_KILL);
    assign fire     = dispatch_valid && dispatch_ready;
    assign pop      = pop_kill || fire;

    // Slot update: commit first, then head pop, then tail push. The popped
    // head is never in WAIT and the push target is always an empty slot, so
    // the three updates never touch the same slot in conflicting ways.
    always_comb begin
        slots_nxt = slots;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (commit_valid && slots[i].st == S_WAIT && slots[i].id == commit_id)
                slots_nxt[i].st = commit_kill ? S_KILL : S_GO;
        end
        if (pop)
            slots_nxt[head].st = S_EMPTY;
        if (push) begin
            slots_nxt[tail].instr    = issue_instr;
            slots_nxt[tail].id       = issue_id;
            slots_nxt[tail].rd       = issue_rd;
            slots_nxt[tail].rd_we    = issue_rd_we;
            slots_nxt[tail].rs       = issue_rs;
            slots_nxt[tail].rs_valid = issue_rs_valid;
            // Commit in the same cycle as issue lands directly in GO/KILL.
            if (commit_valid && issue_id == commit_id)
                slots_nxt[tail].st = commit_kill ? S_KILL : S_GO;
            else
                slots_nxt[tail].st = S_WAIT;
        end
    end

    // Retire clears first so a same-cycle dispatch to the same rd wins.
    always_comb begin
        sb_nxt = sb;
        if (retire_valid)
            sb_nxt[retire_rd] = 1'b0;
        if (fire && head_slot.rd_we)
            sb_nxt[head_slot.rd] = 1'b1;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            slots <= '0;
            head  <= '0;
            tail  <= '0;
            sb    <= '0;
            count <= '0;
        end else begin
            slots <= slots_nxt;
            sb    <= sb_nxt;
            if (pop)  head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
